// File: rtl/div_radix2_core.sv
// rtl/div_radix2_core.sv - 64-bit unsigned restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_FAST_EN: a zero divisor completes in one cycle with the same result.
module div_radix2_core (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  a,
   input  logic [63:0]  b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] c
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [63:0] r_dvd;    // dividend shifts out the top while quotient bits shift in
   logic [63:0] r_dvs;
   logic [63:0] r_rem;
   logic [5:0]  r_cnt;
   logic [64:0] w_t;
   logic        w_accept;
   logic        w_zero_fast;
   logic        w_last;

   assign w_t      = {r_rem, r_dvd[63]} - {1'b0, r_dvs};
   assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
   assign w_last   = (r_cnt == 6'd63);

`ifdef DIV_ZERO_FAST_EN
   assign w_zero_fast = (b == 64'd0);
`else
   assign w_zero_fast = 1'b0;
`endif

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign c         = {r_rem, r_dvd};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next = w_zero_fast ? S_DONE : S_BUSY;
         S_BUSY:  if (w_last) w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (flush) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dvd <= 64'd0;
         r_dvs <= 64'd0;
         r_rem <= 64'd0;
         r_cnt <= 6'd0;
      end else if (w_accept) begin
         r_dvs <= b;
         r_cnt <= 6'd0;
         if (w_zero_fast) begin
            r_rem <= a;
            r_dvd <= {64{1'b1}};
         end else begin
            r_rem <= 64'd0;
            r_dvd <= a;
         end
      end else if (r_state == S_BUSY && !flush) begin
         if (!w_t[64]) begin
            r_rem <= w_t[63:0];
            r_dvd <= {r_dvd[62:0], 1'b1};
         end else begin
            r_rem <= {r_rem[62:0], r_dvd[63]};
            r_dvd <= {r_dvd[62:0], 1'b0};
         end
         r_cnt <= r_cnt + 6'd1;
      end
   end

endmodule

// File: tb/tb_div_radix2_core.sv
// tb/tb_div_radix2_core.sv - directed self-checking bench for div_radix2_core.
// Latency expectations follow DIV_ZERO_FAST_EN when the bench is built with it.
module tb_div_radix2_core;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [63:0]  a = 64'd0;
   logic [63:0]  b = 64'd0;
   logic         in_ready;
   logic         out_valid;
   logic [127:0] c;

   int           n_tests = 0;
   int           n_fail = 0;
   logic [127:0] exp_c = 128'd0;

   localparam logic [63:0] ONES = {64{1'b1}};
`ifdef DIV_ZERO_FAST_EN
   localparam int ZLAT = 0;
`else
   localparam int ZLAT = 64;
`endif

   div_radix2_core dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y);
      if (y == 64'd0) return {x, ONES};
      return {x % y, x / y};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Whenever a result is presented it must match the model for the accepted operands.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         check("cmp_c", c, exp_c);
         check("cmp_ready_excl", {127'd0, in_ready}, 128'd0);
      end
   end

   task automatic accept(input logic [63:0] ta, input logic [63:0] tb_);
      int w;
      w = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("accept_ready", {127'd0, in_ready}, 128'd1);
      a        = ta;
      b        = tb_;
      in_valid = 1'b1;
      exp_c    = model(ta, tb_);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int req_lat);
      int lat;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({name, "_lat"}, lat, req_lat);
   endtask

   task automatic finish_hs(input string name, input logic [127:0] lit, input int hold);
      logic [127:0] snap;
      snap = c;
      check({name, "_c"}, c, lit);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a        = 64'd77;
         b        = 64'd5;
         @(posedge clk);
         @(negedge clk);
         check({name, "_hold_c"}, c, snap);
         check({name, "_hold_rdy"}, {127'd0, in_ready}, 128'd0);
         check({name, "_hold_vld"}, {127'd0, out_valid}, 128'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_idle_rdy"}, {127'd0, in_ready}, 128'd1);
      check({name, "_idle_vld"}, {127'd0, out_valid}, 128'd0);
   endtask

   task automatic run_div(input string name, input logic [63:0] ta, input logic [63:0] tb_,
                          input logic [127:0] lit, input int req_lat, input int hold);
      accept(ta, tb_);
      wait_done(name, req_lat);
      finish_hs(name, lit, hold);
   endtask

   task automatic watch_no_valid(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      check({name, "_no_valid"}, seen, 0);
   endtask

   initial begin
      check("model_100_7", model(64'd100, 64'd7), {64'd2, 64'd14});
      check("model_div0", model(64'h1234, 64'd0), {64'h1234, ONES});
      check("model_big", model(64'd1000000007, 64'd12345), {64'd5627, 64'd81004});

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {127'd0, in_ready}, 128'd1);
      check("rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("rst_c", c, 128'd0);
      reset = 1'b0;

      run_div("basic", 64'd100, 64'd7, {64'd2, 64'd14}, 64, 0);
      run_div("max_by_1", ONES, 64'd1, {64'd0, ONES}, 64, 0);
      run_div("small_by_msb", 64'd5, 64'h8000_0000_0000_0000, {64'd5, 64'd0}, 64, 0);
      run_div("div0", 64'h1234, 64'd0, {64'h1234, ONES}, ZLAT, 0);
      run_div("near_max", ONES, 64'hFFFF_FFFF_FFFF_FFFE, {64'd1, 64'd1}, 64, 0);
      run_div("a_lt_b", 64'd3, 64'd7, {64'd3, 64'd0}, 64, 0);
      run_div("a_eq_b", 64'd42, 64'd42, {64'd0, 64'd1}, 64, 0);
      run_div("backpressure", 64'd1000000007, 64'd12345, {64'd5627, 64'd81004}, 64, 10);

      // flush partway through BUSY
      accept(64'd1000, 64'd3);
      for (int i = 0; i < 19; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check("flush_rdy", {127'd0, in_ready}, 128'd1);
      check("flush_vld", {127'd0, out_valid}, 128'd0);
      watch_no_valid("flush_busy", 70);
      run_div("after_flush", 64'd9, 64'd3, {64'd0, 64'd3}, 64, 0);

      // flush together with a request in IDLE must not accept it
      a        = 64'd50;
      b        = 64'd6;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      check("flush_idle_rdy", {127'd0, in_ready}, 128'd1);
      watch_no_valid("flush_idle", 70);

      // reset while BUSY
      accept(64'd500, 64'd9);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_busy_vld", {127'd0, out_valid}, 128'd0);
      check("rst_busy_c", c, 128'd0);
      check("rst_busy_rdy", {127'd0, in_ready}, 128'd1);
      watch_no_valid("rst_busy", 70);

      // reset while DONE
      accept(64'd20, 64'd6);
      wait_done("pre_rst_done", 64);
      check("pre_rst_done_c", c, {64'd2, 64'd3});
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_done_vld", {127'd0, out_valid}, 128'd0);
      check("rst_done_c", c, 128'd0);
      check("rst_done_rdy", {127'd0, in_ready}, 128'd1);
      run_div("after_reset", 64'd77, 64'd5, {64'd2, 64'd15}, 64, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
